// File: rtl/led_scan_controller.sv
// Purpose: HUB75-style LED panel scanner that queries a painter per pixel and drives the panel strobes.
// Latency: row period = 194 + ON_CYCLES clocks (192 shift, 1 blank, 1 latch, ON_CYCLES display).
// Backpressure: enable low stops scanning only at the next row boundary; a started row always completes.
module led_scan_controller #(
  parameter int unsigned ON_CYCLES = 256,
  parameter int unsigned SUBFRAMES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [5:0]  x,
  output logic [5:0]  y,
  output logic [12:0] frame,
  output logic [7:0]  subframe,
  input  logic [2:0]  rgb,
  output logic [2:0]  panel_rgb0,
  output logic [2:0]  panel_rgb1,
  output logic [4:0]  panel_addr,
  output logic        panel_sclk,
  output logic        panel_lat,
  output logic        panel_oe_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  localparam logic [15:0] ON_LAST  = 16'(ON_CYCLES - 1);
  localparam logic [7:0]  SUB_LAST = 8'(SUBFRAMES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_phase;
  logic [4:0]  r_row;
  logic [15:0] r_cnt;
  logic [5:0]  r_x;
  logic [5:0]  r_y;
  logic [12:0] r_frame;
  logic [7:0]  r_subframe;
  logic [2:0]  r_rgb0;
  logic [2:0]  r_rgb1;
  logic [4:0]  r_addr;
  logic        r_sclk;
  logic        r_lat;
  logic        r_oe_n;

  logic        w_last_col;
  logic        w_disp_done;
  logic        w_row_wrap;
  logic        w_sub_wrap;
  logic        w_sclk_nxt;
  logic        w_lat_nxt;
  logic        w_oe_n_nxt;

  assign w_last_col  = (r_x == 6'd63);
  assign w_disp_done = (r_cnt == ON_LAST);
  assign w_row_wrap  = (r_row == 5'd31);
  assign w_sub_wrap  = (r_subframe == SUB_LAST);

  assign x          = r_x;
  assign y          = r_y;
  assign frame      = r_frame;
  assign subframe   = r_subframe;
  assign panel_rgb0 = r_rgb0;
  assign panel_rgb1 = r_rgb1;
  assign panel_addr = r_addr;
  assign panel_sclk = r_sclk;
  assign panel_lat  = r_lat;
  assign panel_oe_n = r_oe_n;

  // Next state plus the strobe values for the coming cycle (strobes are registered so the panel never sees decode glitches).
  always_comb begin
    w_state_nxt = r_state;
    w_sclk_nxt  = 1'b0;
    w_lat_nxt   = 1'b0;
    w_oe_n_nxt  = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        // Phase 1 is always followed by phase 2, the shift-clock-high cycle.
        if (r_phase == 2'd1) w_sclk_nxt = 1'b1;
        if (r_phase == 2'd2 && w_last_col) w_state_nxt = S_BLANK;
      end
      S_BLANK: begin
        w_state_nxt = S_LATCH;
        w_lat_nxt   = 1'b1;
      end
      S_LATCH: begin
        w_state_nxt = S_DISPLAY;
        w_oe_n_nxt  = 1'b0;
      end
      S_DISPLAY: begin
        if (w_disp_done) w_state_nxt = enable ? S_SHIFT : S_IDLE;
        else             w_oe_n_nxt  = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and registered panel strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sclk  <= 1'b0;
      r_lat   <= 1'b0;
      r_oe_n  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_sclk  <= w_sclk_nxt;
      r_lat   <= w_lat_nxt;
      r_oe_n  <= w_oe_n_nxt;
    end
  end

  // Datapath: painter query coordinates, shift data capture, row/subframe/frame counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase    <= 2'd0;
      r_row      <= 5'd0;
      r_cnt      <= 16'd0;
      r_x        <= 6'd0;
      r_y        <= 6'd0;
      r_frame    <= 13'd0;
      r_subframe <= 8'd0;
      r_rgb0     <= 3'd0;
      r_rgb1     <= 3'd0;
      r_addr     <= 5'd0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          case (r_phase)
            2'd0: begin
              r_rgb0  <= rgb;
              r_y     <= {1'b1, r_row};
              r_phase <= 2'd1;
            end
            2'd1: begin
              r_rgb1  <= rgb;
              r_phase <= 2'd2;
            end
            default: begin
              r_phase <= 2'd0;
              // x stays at 63 after the last column; it is rewound at display exit.
              if (!w_last_col) begin
                r_x <= r_x + 6'd1;
                r_y <= {1'b0, r_row};
              end
            end
          endcase
        end
        S_BLANK: begin
          r_addr <= r_row;
          r_cnt  <= 16'd0;
        end
        S_DISPLAY: begin
          if (w_disp_done) begin
            r_cnt <= 16'd0;
            r_row <= r_row + 5'd1;
            r_x   <= 6'd0;
            r_y   <= {1'b0, r_row + 5'd1};
            if (w_row_wrap) begin
              if (w_sub_wrap) begin
                r_subframe <= 8'd0;
                r_frame    <= r_frame + 13'd1;
              end else begin
                r_subframe <= r_subframe + 8'd1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_controller.sv
// Purpose: scoreboard bench for led_scan_controller with a random painter image and random enable gaps.
// Latency: expected rows are queued ahead of the DUT; a negedge monitor pops on every sclk and latch strobe.
// Backpressure: waits on DUT progress are cycle-bounded; an expired bound is reported as a failed comparison.
module tb_led_scan_controller;

  localparam int ON   = 8;
  localparam int SUBF = 2;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [5:0]  x;
  logic [5:0]  y;
  logic [12:0] frame;
  logic [7:0]  subframe;
  logic [2:0]  rgb;
  logic [2:0]  panel_rgb0;
  logic [2:0]  panel_rgb1;
  logic [4:0]  panel_addr;
  logic        panel_sclk;
  logic        panel_lat;
  logic        panel_oe_n;

  logic [2:0] pic [64][64];

  led_scan_controller #(.ON_CYCLES(ON), .SUBFRAMES(SUBF)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .x          (x),
    .y          (y),
    .frame      (frame),
    .subframe   (subframe),
    .rgb        (rgb),
    .panel_rgb0 (panel_rgb0),
    .panel_rgb1 (panel_rgb1),
    .panel_addr (panel_addr),
    .panel_sclk (panel_sclk),
    .panel_lat  (panel_lat),
    .panel_oe_n (panel_oe_n)
  );

  // Combinational painter: answers the current (x,y) query from the image table.
  assign rgb = pic[y][x];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int x; int rgb0; int rgb1; int sub; int frm; } pix_t;
  typedef struct { int addr; int sub; int frm; } lat_t;

  pix_t pix_q[$];
  lat_t lat_q[$];
  int   m_row = 0;
  int   m_sub = 0;
  int   m_frm = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   lat_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: rows are scanned 0..31 in order; every 32 rows is a subframe, every SUBF subframes a frame.
  function automatic void push_row();
    pix_t p;
    lat_t l;
    for (int c = 0; c < 64; c++) begin
      p.x    = c;
      p.rgb0 = int'(pic[m_row][c]);
      p.rgb1 = int'(pic[m_row + 32][c]);
      p.sub  = m_sub;
      p.frm  = m_frm;
      pix_q.push_back(p);
    end
    l.addr = m_row;
    l.sub  = m_sub;
    l.frm  = m_frm;
    lat_q.push_back(l);
    m_row = (m_row + 1) % 32;
    if (m_row == 0) begin
      m_sub = (m_sub + 1) % SUBF;
      if (m_sub == 0) m_frm = (m_frm + 1) % 8192;
    end
  endfunction

  task automatic top_up();
    while (lat_q.size() < 2) push_row();
  endtask

  task automatic flush_model();
    pix_q.delete();
    lat_q.delete();
    m_row = 0;
    m_sub = 0;
    m_frm = 0;
  endtask

  task automatic step();
    @(negedge clk);
    #2;
    top_up();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_frame"}, frame, 0);
    chk({tag, "_subframe"}, subframe, 0);
    chk({tag, "_rgb0"}, panel_rgb0, 0);
    chk({tag, "_rgb1"}, panel_rgb1, 0);
    chk({tag, "_addr"}, panel_addr, 0);
    chk({tag, "_sclk"}, panel_sclk, 0);
    chk({tag, "_lat"}, panel_lat, 0);
    chk({tag, "_oe_n"}, panel_oe_n, 1);
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return panel_sclk == 1'b1;
      1:       return panel_lat == 1'b1;
      default: return panel_sclk == 1'b1 && x == 6'd10;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int budget);
    int b = budget;
    while (!cond(which) && b > 0) begin
      step();
      b--;
    end
    if (!cond(which)) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_rows(input int n, input bit rnd);
    int target = lat_seen + n;
    int budget = n * (194 + ON) * 3 + 2000;
    int idle = 0;
    while (lat_seen < target && budget > 0) begin
      if (rnd) begin
        if (idle > 0) begin
          idle--;
          if (idle == 0) enable = 1'b1;
        end else if ($urandom_range(0, 199) == 0) begin
          enable = 1'b0;
          idle = $urandom_range(1, 60);
        end
      end
      step();
      budget--;
    end
    enable = 1'b1;
    if (lat_seen < target) chk("run_rows_timeout", lat_seen, target);
  endtask

  // Monitor: pops the scoreboard on every shift clock and latch, and checks strobe timing.
  pix_t mp;
  lat_t ml;
  int sclk_in_row = 0;
  int last_sclk = 0;
  int last_lat = 0;
  int oe_run = 0;
  always @(negedge clk) begin
    if (reset) begin
      sclk_in_row = 0;
      oe_run = 0;
    end else begin
      if (panel_sclk || panel_lat) chk("sclk_lat_exclusive", panel_sclk & panel_lat, 0);
      if (panel_sclk) begin
        if (pix_q.size() == 0) begin
          chk("pix_underflow", pix_q.size(), 1);
        end else begin
          mp = pix_q.pop_front();
          chk("sclk_x", x, mp.x);
          chk("rgb0", panel_rgb0, mp.rgb0);
          chk("rgb1", panel_rgb1, mp.rgb1);
          chk("row_subframe", subframe, mp.sub);
          chk("row_frame", frame, mp.frm);
        end
        if (sclk_in_row > 0) chk("sclk_spacing", cyc - last_sclk, 3);
        sclk_in_row++;
        last_sclk = cyc;
      end
      if (panel_lat) begin
        if (lat_q.size() == 0) begin
          chk("lat_underflow", lat_q.size(), 1);
        end else begin
          ml = lat_q.pop_front();
          chk("lat_addr", panel_addr, ml.addr);
          chk("lat_subframe", subframe, ml.sub);
          chk("lat_frame", frame, ml.frm);
        end
        chk("sclk_per_row", sclk_in_row, 64);
        chk("sclk_to_lat", cyc - last_sclk, 2);
        chk("x_at_latch", x, 63);
        sclk_in_row = 0;
        last_lat = cyc;
        lat_seen++;
      end
      if (!panel_oe_n) begin
        if (oe_run == 0) chk("display_after_latch", cyc - last_lat, 1);
        oe_run++;
      end else if (oe_run > 0) begin
        chk("display_len", oe_run, ON);
        oe_run = 0;
      end
    end
  end

  int n_sclk;
  int n_lat;
  int n_disp;
  int ny;

  initial begin
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        pic[r][c] = 3'($urandom_range(0, 7));
    reset  = 1'b1;
    enable = 1'b0;
    flush_model();
    top_up();
    repeat (3) step();
    check_reset("por");

    // First row after reset release: exact strobe positions relative to the first SHIFT cycle t0.
    enable = 1'b1;
    reset  = 1'b0;
    n_sclk = 0;
    n_lat  = 0;
    n_disp = 0;
    for (int k = 0; k <= 194 + ON; k++) begin
      step();
      if (k <= 193 && panel_sclk) n_sclk++;
      if (panel_lat) n_lat++;
      if (!panel_oe_n) n_disp++;
      if (k == 0) begin chk("t0_x", x, 0); chk("t0_y", y, 0); chk("t0_sclk", panel_sclk, 0); end
      if (k == 1) begin chk("t1_x", x, 0); chk("t1_y", y, 32); end
      if (k == 2) chk("t2_sclk", panel_sclk, 1);
      if (k == 3) begin chk("t3_x", x, 1); chk("t3_y", y, 0); chk("t3_sclk", panel_sclk, 0); end
      if (k == 191) begin chk("t191_sclk", panel_sclk, 1); chk("t191_x", x, 63); end
      if (k == 192) begin chk("blank_oe_n", panel_oe_n, 1); chk("blank_lat", panel_lat, 0); chk("blank_sclk", panel_sclk, 0); end
      if (k == 193) begin chk("latch_lat", panel_lat, 1); chk("latch_addr", panel_addr, 0); end
      if (k == 194) chk("disp_first_oe_n", panel_oe_n, 0);
      if (k == 193 + ON) chk("disp_last_oe_n", panel_oe_n, 0);
      if (k == 194 + ON) begin chk("row1_x", x, 0); chk("row1_y", y, 1); chk("row1_oe_n", panel_oe_n, 1); end
    end
    chk("first_row_sclk_count", n_sclk, 64);
    chk("first_row_lat_count", n_lat, 1);
    chk("first_row_disp_count", n_disp, ON);

    // Long run across subframe and frame wraps with random enable gaps.
    run_rows(140, 1'b1);

    // Enable dropped at column 10: the row completes, then the scanner idles at the next row.
    wait_for("col10", 2, 2000);
    enable = 1'b0;
    run_rows(1, 1'b0);
    enable = 1'b0;
    repeat (ON + 1) step();
    ny = lat_q[0].addr;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("idle_oe_n", panel_oe_n, 1);
      chk("idle_sclk", panel_sclk, 0);
      chk("idle_x", x, 0);
      chk("idle_y", y, ny);
    end
    enable = 1'b1;
    step();
    chk("resume_x", x, 0);
    chk("resume_y", y, ny);
    step();
    chk("resume_y_lower", y, ny + 32);
    run_rows(3, 1'b0);

    // Reset in a shift-clock-high cycle.
    wait_for("sclk_hi", 0, 2000);
    reset = 1'b1;
    #1;
    check_reset("rst_sclk");
    flush_model();
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("restart_x", x, 0);
    chk("restart_y", y, 0);
    run_rows(2, 1'b0);

    // Reset in a latch cycle.
    wait_for("lat_hi", 1, 2000);
    reset = 1'b1;
    #1;
    check_reset("rst_lat");
    flush_model();
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("restart2_x", x, 0);
    chk("restart2_y", y, 0);
    run_rows(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
